// File: rtl/pipeline_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pipeline_pkg : shared encodings and the Execute->mem1 bundle type      |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package pipeline_pkg;

    localparam int DATA_W    = 32;
    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_READ  = 2'b01,
        MEM_WRITE = 2'b10
    } mem_rw_e;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_e;

    localparam logic [2:0] LEN_BYTE   = 3'd0;
    localparam logic [2:0] LEN_HALF   = 3'd1;
    localparam logic [2:0] LEN_WORD   = 3'd2;
    localparam logic [2:0] LEN_BYTE_U = 3'd4;
    localparam logic [2:0] LEN_HALF_U = 3'd5;

    typedef struct packed {
        logic [DATA_W-1:0]    pc;
        logic [DATA_W-1:0]    result;
        logic [REG_IDX_W-1:0] rd_index;
        logic [2:0]           number_length;
        logic [1:0]           memory_rw;
        logic                 writeback_valid;
        logic                 writeback_src;
    } ex_bundle_t;

    // x0 is hardwired zero, so a write to it must never be forwarded.
    function automatic logic writes_real_reg(input ex_bundle_t b);
        return b.writeback_valid && (b.rd_index != '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mem1_link_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ex_mem1_link_if : valid/ready bundle channel between pipeline stages   |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
interface ex_mem1_link_if;
    import pipeline_pkg::*;

    logic                 valid;
    logic                 ready;
    logic [DATA_W-1:0]    pc;
    logic [DATA_W-1:0]    result;
    logic [REG_IDX_W-1:0] rd_index;
    logic [2:0]           number_length;
    logic [1:0]           memory_rw;
    logic                 writeback_valid;
    logic                 writeback_src;

    modport master (
        output valid, pc, result, rd_index, number_length, memory_rw,
               writeback_valid, writeback_src,
        input  ready
    );

    modport slave (
        input  valid, pc, result, rd_index, number_length, memory_rw,
               writeback_valid, writeback_src,
        output ready
    );

endinterface
`default_nettype wire

// File: rtl/ex_mem1_slot.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ex_mem1_slot : one valid bit plus bundle payload, load beats clear     |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module ex_mem1_slot
    import pipeline_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rstn,
    input  wire logic       load,
    input  wire logic       clear,
    input  wire ex_bundle_t d,
    output logic            valid,
    output ex_bundle_t      q
);

    logic       valid_q, valid_d;
    ex_bundle_t data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = d;
        end else if (clear) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign q     = data_q;

endmodule
`default_nettype wire

// File: rtl/ex_mem1_link.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ex_mem1_link : Execute->mem1 buffer with forwarding and flush.         |
// | EX_MEM1_SKID_EN adds a skid slot so ex.ready is registered.            |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module ex_mem1_link
    import pipeline_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               rstn,
    input  wire logic               flush,
    ex_mem1_link_if.slave           ex,
    ex_mem1_link_if.master          m1,
    output logic [DATA_W-1:0]       mem1_out,
    output logic [REG_IDX_W-1:0]    mem1_rd_index,
    output logic                    mem1_rd_we,
    output logic                    mem1_load_pending
);

    ex_bundle_t ex_bundle;
    ex_bundle_t main_bundle;
    ex_bundle_t main_in;
    logic       main_valid;
    logic       main_load;
    logic       main_clear;
    logic       drain;
    logic       up;

    assign ex_bundle = '{pc:              ex.pc,
                         result:          ex.result,
                         rd_index:        ex.rd_index,
                         number_length:   ex.number_length,
                         memory_rw:       ex.memory_rw,
                         writeback_valid: ex.writeback_valid,
                         writeback_src:   ex.writeback_src};

    assign drain = main_valid & m1.ready;
    assign up    = ex.valid & ex.ready;

`ifdef EX_MEM1_SKID_EN
    ex_bundle_t skid_bundle;
    logic       skid_valid;
    logic       skid_load;
    logic       skid_clear;
    logic       main_from_skid;

    always_comb begin
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else if (drain && skid_valid) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
        end else if (!main_valid || drain) begin
            main_load  = up;
            main_clear = !up;
        end else begin
            skid_load = up;
        end
    end

    assign main_in  = main_from_skid ? skid_bundle : ex_bundle;
    // skid_valid is a flop, so ready never depends on m1.ready this cycle.
    assign ex.ready = !skid_valid;

    ex_mem1_slot u_skid (
        .clk   (clk),
        .rstn  (rstn),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (ex_bundle),
        .valid (skid_valid),
        .q     (skid_bundle)
    );
`else
    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        if (flush) begin
            main_clear = 1'b1;
        end else if (!main_valid || drain) begin
            main_load  = up;
            main_clear = !up;
        end
    end

    assign main_in  = ex_bundle;
    assign ex.ready = !main_valid | m1.ready;
`endif

    ex_mem1_slot u_main (
        .clk   (clk),
        .rstn  (rstn),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_in),
        .valid (main_valid),
        .q     (main_bundle)
    );

    assign m1.valid           = main_valid;
    assign m1.pc              = main_bundle.pc;
    assign m1.result          = main_bundle.result;
    assign m1.rd_index        = main_bundle.rd_index;
    assign m1.number_length   = main_bundle.number_length;
    assign m1.memory_rw       = main_bundle.memory_rw;
    assign m1.writeback_valid = main_bundle.writeback_valid;
    assign m1.writeback_src   = main_bundle.writeback_src;

    assign mem1_out          = main_bundle.result;
    assign mem1_rd_index     = main_bundle.rd_index;
    assign mem1_rd_we        = main_valid && writes_real_reg(main_bundle)
                               && (main_bundle.writeback_src == WB_SRC_ALU);
    assign mem1_load_pending = main_valid && writes_real_reg(main_bundle)
                               && (main_bundle.writeback_src == WB_SRC_MEM);

endmodule
`default_nettype wire

// File: tb/tb_ex_mem1_link.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_ex_mem1_link : directed self-checking bench for ex_mem1_link        |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tb_ex_mem1_link;
    import pipeline_pkg::*;

    logic clk;
    logic rstn;
    logic flush;
    logic [DATA_W-1:0]    mem1_out;
    logic [REG_IDX_W-1:0] mem1_rd_index;
    logic                 mem1_rd_we;
    logic                 mem1_load_pending;

    int n_checks = 0;
    int n_errors = 0;

    ex_mem1_link_if ex_if ();
    ex_mem1_link_if m1_if ();

    ex_mem1_link dut (
        .clk               (clk),
        .rstn              (rstn),
        .flush             (flush),
        .ex                (ex_if),
        .m1                (m1_if),
        .mem1_out          (mem1_out),
        .mem1_rd_index     (mem1_rd_index),
        .mem1_rd_we        (mem1_rd_we),
        .mem1_load_pending (mem1_load_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] rd,
                         input logic wbv, input logic src, input logic [1:0] mrw,
                         input logic [2:0] nl);
        ex_if.valid           = v;
        ex_if.result          = res;
        ex_if.pc              = res + 32'h100;
        ex_if.rd_index        = rd;
        ex_if.writeback_valid = wbv;
        ex_if.writeback_src   = src;
        ex_if.memory_rw       = mrw;
        ex_if.number_length   = nl;
    endtask

    initial begin
        rstn        = 1'b0;
        flush       = 1'b0;
        m1_if.ready = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 3'd0);
        #3;
        check("rst_m1_valid", {31'b0, m1_if.valid}, 32'd0);
        check("rst_ex_ready", {31'b0, ex_if.ready}, 32'd1);
        check("rst_m1_result", m1_if.result, 32'd0);
        #9 rstn = 1'b1;
        tick();

        // Streaming: one bundle per cycle, each visible one cycle after accept.
        m1_if.ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'h11 * i, 5'd3, 1'b1, 1'b0, 2'b00, LEN_WORD);
            #1;
            check("stream_ex_ready", {31'b0, ex_if.ready}, 32'd1);
            tick();
            check("stream_m1_valid", {31'b0, m1_if.valid}, 32'd1);
            check("stream_m1_result", m1_if.result, 32'h11 * i);
            check("stream_m1_pc", m1_if.pc, 32'h11 * i + 32'h100);
        end
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 3'd0);
        tick();
        check("stream_empty", {31'b0, m1_if.valid}, 32'd0);

        // Backpressure: three stalled cycles, then release.
        m1_if.ready = 1'b0;
        drive(1'b1, 32'hA1, 5'd4, 1'b1, 1'b0, 2'b00, LEN_WORD);
        #1;
        check("bp_ready_c0", {31'b0, ex_if.ready}, 32'd1);
        tick();
        check("bp_main_c0", m1_if.result, 32'hA1);
`ifdef EX_MEM1_SKID_EN
        drive(1'b1, 32'hA2, 5'd4, 1'b1, 1'b0, 2'b00, LEN_WORD);
        #1;
        check("bp_ready_c1", {31'b0, ex_if.ready}, 32'd1);
        tick();
        check("bp_main_c1", m1_if.result, 32'hA1);
        drive(1'b1, 32'hA3, 5'd4, 1'b1, 1'b0, 2'b00, LEN_WORD);
        #1;
        check("bp_ready_c2", {31'b0, ex_if.ready}, 32'd0);
        tick();
        check("bp_main_c2", m1_if.result, 32'hA1);
        check("bp_valid_c2", {31'b0, m1_if.valid}, 32'd1);
        m1_if.ready = 1'b1;
        #1;
        check("bp_ready_c3", {31'b0, ex_if.ready}, 32'd0);
        tick();
        check("bp_out_a2", m1_if.result, 32'hA2);
        #1;
        check("bp_ready_c4", {31'b0, ex_if.ready}, 32'd1);
        tick();
        check("bp_out_a3", m1_if.result, 32'hA3);
`else
        drive(1'b1, 32'hA2, 5'd4, 1'b1, 1'b0, 2'b00, LEN_WORD);
        #1;
        check("bp_ready_c1", {31'b0, ex_if.ready}, 32'd0);
        tick();
        check("bp_main_c1", m1_if.result, 32'hA1);
        #1;
        check("bp_ready_c2", {31'b0, ex_if.ready}, 32'd0);
        tick();
        check("bp_main_c2", m1_if.result, 32'hA1);
        check("bp_valid_c2", {31'b0, m1_if.valid}, 32'd1);
        m1_if.ready = 1'b1;
        #1;
        check("bp_ready_c3", {31'b0, ex_if.ready}, 32'd1);
        tick();
        check("bp_out_a2", m1_if.result, 32'hA2);
        drive(1'b1, 32'hA3, 5'd4, 1'b1, 1'b0, 2'b00, LEN_WORD);
        m1_if.ready = 1'b0;
        #1;
        check("bp_ready_toggle0", {31'b0, ex_if.ready}, 32'd0);
        m1_if.ready = 1'b1;
        #1;
        check("bp_ready_toggle1", {31'b0, ex_if.ready}, 32'd1);
        tick();
        check("bp_out_a3", m1_if.result, 32'hA3);
`endif
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 3'd0);
        tick();
        check("bp_empty", {31'b0, m1_if.valid}, 32'd0);

        // Flush beats a simultaneous accept.
        drive(1'b1, 32'hF1, 5'd5, 1'b1, 1'b0, 2'b00, LEN_WORD);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 3'd0);
        check("flush_arrive_valid", {31'b0, m1_if.valid}, 32'd0);
        tick();
        check("flush_never_seen", {31'b0, m1_if.valid}, 32'd0);

        // Flush clears a held entry under backpressure.
        m1_if.ready = 1'b0;
        drive(1'b1, 32'hB1, 5'd5, 1'b1, 1'b0, 2'b00, LEN_WORD);
        tick();
        drive(1'b1, 32'hB2, 5'd5, 1'b1, 1'b0, 2'b00, LEN_WORD);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 3'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_held_valid", {31'b0, m1_if.valid}, 32'd0);
        check("flush_held_ready", {31'b0, ex_if.ready}, 32'd1);

        // Forwarding gating.
        drive(1'b1, 32'h5, 5'd0, 1'b1, WB_SRC_ALU, MEM_NONE, LEN_WORD);
        tick();
        check("fwd_rd0_valid", {31'b0, m1_if.valid}, 32'd1);
        check("fwd_rd0_we", {31'b0, mem1_rd_we}, 32'd0);
        check("fwd_rd0_lp", {31'b0, mem1_load_pending}, 32'd0);
        m1_if.ready = 1'b1;
        drive(1'b1, 32'hDEADBEEF, 5'd7, 1'b1, WB_SRC_ALU, MEM_NONE, LEN_WORD);
        tick();
        check("fwd_alu_we", {31'b0, mem1_rd_we}, 32'd1);
        check("fwd_alu_out", mem1_out, 32'hDEADBEEF);
        check("fwd_alu_idx", {27'b0, mem1_rd_index}, 32'd7);
        check("fwd_alu_lp", {31'b0, mem1_load_pending}, 32'd0);
        drive(1'b1, 32'h1234, 5'd7, 1'b1, WB_SRC_MEM, MEM_READ, LEN_HALF_U);
        tick();
        check("fwd_mem_we", {31'b0, mem1_rd_we}, 32'd0);
        check("fwd_mem_lp", {31'b0, mem1_load_pending}, 32'd1);
        check("fwd_mem_rw", {30'b0, m1_if.memory_rw}, 32'd1);
        check("fwd_mem_len", {29'b0, m1_if.number_length}, 32'd5);
        drive(1'b1, 32'h99, 5'd7, 1'b0, WB_SRC_ALU, MEM_WRITE, LEN_BYTE);
        tick();
        check("fwd_nowb_we", {31'b0, mem1_rd_we}, 32'd0);
        check("fwd_nowb_lp", {31'b0, mem1_load_pending}, 32'd0);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 3'd0);
        tick();
        check("fwd_empty_we", {31'b0, mem1_rd_we}, 32'd0);

        // Asynchronous reset mid-stream, between clock edges.
        m1_if.ready = 1'b0;
        drive(1'b1, 32'hC0FFEE, 5'd9, 1'b1, WB_SRC_ALU, MEM_NONE, LEN_WORD);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 3'd0);
        check("arst_pre_valid", {31'b0, m1_if.valid}, 32'd1);
        check("arst_pre_we", {31'b0, mem1_rd_we}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("arst_valid", {31'b0, m1_if.valid}, 32'd0);
        check("arst_ready", {31'b0, ex_if.ready}, 32'd1);
        check("arst_we", {31'b0, mem1_rd_we}, 32'd0);
        check("arst_result", m1_if.result, 32'd0);
        #2 rstn = 1'b1;
        tick();
        check("arst_after_valid", {31'b0, m1_if.valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_mem1_link.md
Name: ex_mem1_link

Overview:
- Pipeline link between the Execute stage and the first memory stage (mem1).
- Receives Execute's result and pass-through control signals over a valid/ready handshake and buffers them.
- Presents the buffered bundle to mem1, and drives the mem1 forwarding triple (mem1_out, mem1_rd_index, mem1_rd_we) back into Execute.
- Provides flush for branch and exception redirect.

Parameters:
DATA_W, 32, width of result and pc
REG_IDX_W, 5, register index width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of all held entries
ex_valid  in  1  Execute bundle valid
ex_ready  out  1  link can accept
ex_pc  in  DATA_W  instruction pc
ex_result  in  DATA_W  Execute result
ex_rd_index  in  REG_IDX_W  destination register
ex_number_length  in  3  memory access length code
ex_memory_rw  in  2  memory op code: 00 none, 01 read, 10 write
ex_writeback_valid  in  1  instruction writes rd
ex_writeback_src  in  1  0 = ALU result, 1 = memory data
m1_valid  out  1  bundle valid to mem1
m1_ready  in  1  mem1 accepts
m1_pc, m1_result, m1_rd_index, m1_number_length, m1_memory_rw, m1_writeback_valid, m1_writeback_src  out  (widths as ex_*)  held bundle
mem1_out  out  DATA_W  forwarding data (= m1_result)
mem1_rd_index  out  REG_IDX_W  forwarding index
mem1_rd_we  out  1  forwarding enable
mem1_load_pending  out  1  load-use hazard indicator

Behaviour:
- Clock and reset: single clock clk; reset rstn is asynchronous, active-low.
- Reset values: all valid bits 0; all payload registers 0; ex_ready 1.
- Transfers:
  - Upstream transfer when ex_valid & ex_ready.
  - Downstream transfer when m1_valid & m1_ready.
- Storage: main slot (drives m1_*) plus skid slot.
- ex_ready = !skid_valid, taken from a register (no combinational path from m1_ready).
- Each cycle, without flush:
  - Main empty, or main draining, with skid empty: upstream bundle loads main.
  - Main full, not draining, upstream transfer: bundle loads skid.
  - Main draining with skid full: skid moves to main, skid clears; ex_ready is 0 that cycle, so nothing is accepted.
  - Main draining, skid empty, no upstream: main_valid clears.
- Ordering: strict FIFO order, no reordering; accepted bundles are never dropped or duplicated.
- Latency: 1 cycle from upstream accept to m1_valid.
- Throughput: 1 bundle/cycle with m1_ready held high.
- Simultaneous accept and drain: a bundle is accepted and another emitted in the same edge.
- Flush: at the edge, main_valid and skid_valid clear; flush wins over a simultaneous upstream accept; payload registers may keep stale values.
- m1_valid stability: m1_valid and the m1_* payload hold stable while m1_valid & !m1_ready.
- Forwarding:
  - mem1_rd_we = m1_valid & m1_writeback_valid & !m1_writeback_src & (m1_rd_index != 0).
  - mem1_load_pending = m1_valid & m1_writeback_valid & m1_writeback_src & (m1_rd_index != 0).
  - Both are combinational from the main slot only; the skid entry is not forwarded.
- Reset mid-operation: entries are lost immediately; outputs go to reset values asynchronously.

Optional Feature:
- Macro EX_MEM1_SKID_EN.
- Defined: two-slot skid behaviour as above; ex_ready is registered.
- Undefined:
  - No skid slot; single main register.
  - ex_ready = !m1_valid | m1_ready, combinational.
  - Throughput, latency and forwarding are unchanged.

Decomposition:
- Shared package pipeline_pkg:
  - memory_rw encodings (MEM_NONE, MEM_READ, MEM_WRITE)
  - writeback_src encodings (WB_SRC_ALU, WB_SRC_MEM)
  - number_length codes
  - a packed ex_bundle_t struct holding pc, result, rd_index and control fields
- Sub-module ex_mem1_slot: one valid+payload register with load/clear enables, instantiated once per slot.

Test Plan:
- Reset: rstn low mid-stream with m1_valid=1 -> m1_valid=0, ex_ready=1, mem1_rd_we=0 immediately, without waiting for a clock edge.
- Streaming: 8 bundles with results 0x11..0x88, m1_ready=1 -> m1_result sequence 0x11..0x88 on consecutive cycles, each 1 cycle after accept.
- Backpressure: m1_ready=0 for 3 cycles while ex_valid=1 -> one bundle held in main, one in skid, ex_ready=0; after m1_ready=1 all emerge in order, no loss or duplicate.
- Flush with bundle arriving: flush=1 same cycle as ex_valid=1 -> next cycle m1_valid=0, and the arriving bundle never appears downstream.
- Forwarding gating: rd=0 with writeback_valid=1 -> mem1_rd_we=0; rd=7, src=ALU, result 0xDEADBEEF -> mem1_rd_we=1, mem1_out=0xDEADBEEF; rd=7, src=MEM -> mem1_rd_we=0, mem1_load_pending=1.
- Macro off: build without EX_MEM1_SKID_EN, m1_ready toggling 1/0 -> ex_ready follows !m1_valid|m1_ready in the same cycle; order preserved.
